// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares one data-memory port between the MEM stage and a debug port,
//            guaranteeing the debug side a slot within MAX_WAIT busy cycles.
// Options  : DMEM_ARB_PERF_EN adds saturating stall/debug-access counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // pipeline (primary) side
  input  logic                  p_ren,
  input  logic                  p_wen,
  input  logic [2:0]            p_type,
  input  logic [WORD_WIDTH-1:0] p_addr,
  input  logic [WORD_WIDTH-1:0] p_wd,
  output logic [WORD_WIDTH-1:0] p_rd,
  output logic                  p_stall,
  // debug / loader (secondary) side
  input  logic                  d_req,
  output logic                  d_rdy,
  input  logic                  d_wen,
  input  logic [2:0]            d_type,
  input  logic [WORD_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wd,
  output logic                  d_ack,
  output logic [WORD_WIDTH-1:0] d_rd,
  // data memory side
  output logic                  m_wen,
  output logic [2:0]            m_type,
  output logic [WORD_WIDTH-1:0] m_addr,
  output logic [WORD_WIDTH-1:0] m_wd,
  input  logic [WORD_WIDTH-1:0] m_rd,
  // performance counters
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_dbg
);

  localparam int                 c_CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    S_PIPE = 1'b0,
    S_DBG  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_CNT_W-1:0]      w_cnt_nxt;
  logic                    r_dbg_pend;
  logic                    r_hold_wen;
  logic [2:0]              r_hold_type;
  logic [WORD_WIDTH-1:0]   r_hold_addr;
  logic [WORD_WIDTH-1:0]   r_hold_wd;
  logic                    r_d_ack;
  logic [WORD_WIDTH-1:0]   r_d_rd;

  logic                    w_p_req;
  logic                    w_accept;
  logic                    w_dbg_done;
  logic                    w_m_wen;

  assign w_p_req  = p_ren | p_wen;
  assign d_rdy    = ~r_dbg_pend;
  assign w_accept = d_req & ~r_dbg_pend;

  assign p_rd  = m_rd;
  assign d_ack = r_d_ack;
  assign d_rd  = r_d_rd;
  // A store must never reach memory while the system is being reset.
  assign m_wen = w_m_wen & ~rst;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dbg_done  = 1'b0;
    p_stall     = 1'b0;
    w_m_wen     = p_wen;
    m_type      = p_type;
    m_addr      = p_addr;
    m_wd        = p_wd;
    case (r_state)
      S_PIPE: begin
        if (r_dbg_pend && (!w_p_req || r_cnt == c_CNT_LAST)) begin
          w_state_nxt = S_DBG;
        end else if (r_dbg_pend && w_p_req) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DBG: begin
        w_m_wen     = r_hold_wen;
        m_type      = r_hold_type;
        m_addr      = r_hold_addr;
        m_wd        = r_hold_wd;
        p_stall     = w_p_req;
        w_dbg_done  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_PIPE;
      end
      default: begin
        w_state_nxt = S_PIPE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_PIPE;
      r_cnt       <= '0;
      r_dbg_pend  <= 1'b0;
      r_hold_wen  <= 1'b0;
      r_hold_type <= '0;
      r_hold_addr <= '0;
      r_hold_wd   <= '0;
      r_d_ack     <= 1'b0;
      r_d_rd      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d_ack <= w_dbg_done;
      if (w_dbg_done) begin
        r_d_rd     <= m_rd;
        r_dbg_pend <= 1'b0;
      end else if (w_accept) begin
        r_hold_wen  <= d_wen;
        r_hold_type <= d_type;
        r_hold_addr <= d_addr;
        r_hold_wd   <= d_wd;
        r_dbg_pend  <= 1'b1;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_dbg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_dbg   <= '0;
    end else begin
      if (p_stall && r_perf_stall != 32'hFFFF_FFFF) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_dbg_done && r_perf_dbg != 32'hFFFF_FFFF) begin
        r_perf_dbg <= r_perf_dbg + 32'd1;
      end
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_dbg   = r_perf_dbg;
`else
  assign perf_stall = '0;
  assign perf_dbg   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Directed scoreboard bench for dmem_port_arbiter with a word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_ren, p_wen;
  logic [2:0]  p_type;
  logic [31:0] p_addr, p_wd, p_rd;
  logic        p_stall;
  logic        d_req, d_rdy, d_wen;
  logic [2:0]  d_type;
  logic [31:0] d_addr, d_wd;
  logic        d_ack;
  logic [31:0] d_rd;
  logic        m_wen;
  logic [2:0]  m_type;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [31:0] perf_stall, perf_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ack_cyc = -100;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  dmem_port_arbiter #(.WORD_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_ren(p_ren), .p_wen(p_wen), .p_type(p_type), .p_addr(p_addr), .p_wd(p_wd),
    .p_rd(p_rd), .p_stall(p_stall),
    .d_req(d_req), .d_rdy(d_rdy), .d_wen(d_wen), .d_type(d_type), .d_addr(d_addr),
    .d_wd(d_wd), .d_ack(d_ack), .d_rd(d_rd),
    .m_wen(m_wen), .m_type(m_type), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd),
    .perf_stall(perf_stall), .perf_dbg(perf_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-addressed data memory with combinational read, cleared on first edge.
  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;
  assign m_rd = mem[m_addr[7:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem_ready <= 1'b1;
    end else if (m_wen) begin
      mem[m_addr[7:2]] <= m_wd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every debug completion is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && d_ack === 1'b1) begin
      last_ack_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: d_ack=1 with no access outstanding (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check("d_rd_load", d_rd, e.data);
      end
    end
  end

  task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           input logic push, input logic [31:0] exp_data);
    @(posedge clk); #1;
    d_req  = 1'b1;
    d_wen  = wen;
    d_type = 3'b010;
    d_addr = addr;
    d_wd   = wd;
    if (push) exp_q.push_back('{chk: ~wen, data: exp_data});
    @(negedge clk);
    check("d_rdy_accept", {31'd0, d_rdy}, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  // Counts pending cycles until the held debug access appears on the memory port.
  task automatic wait_access(input logic [31:0] addr, input logic wen, input int exp_wait,
                             input logic exp_stall, output int acc_cyc);
    int n = 0;
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_addr === addr && m_wen === wen) begin
        found = 1;
        break;
      end
      check("p_stall_pending", {31'd0, p_stall}, 32'd0);
      check("d_rdy_pending", {31'd0, d_rdy}, 32'd0);
      n++;
      @(posedge clk); #1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr 0x%08h never reached memory port", addr);
      acc_cyc = -1000;
    end else begin
      check("wait_cycles", n, exp_wait);
      check("p_stall_access", {31'd0, p_stall}, {31'd0, exp_stall});
      check("m_type_access", {29'd0, m_type}, 32'd2);
      if (wen) check("m_wd_access", m_wd, d_wd);
      acc_cyc = cyc;
    end
  endtask

  task automatic finish_ack(input int acc_cyc);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("d_ack_cycle", last_ack_cyc, acc_cyc + 1);
    check("d_ack_pulse", {31'd0, d_ack}, 32'd1);
    check("d_rdy_in_ack", {31'd0, d_rdy}, 32'd1);
    @(negedge clk);
    check("d_ack_drop", {31'd0, d_ack}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc;
    rst = 1'b1;
    p_ren = 1'b0; p_wen = 1'b1; p_type = 3'b010; p_addr = 32'h100; p_wd = 32'h55;
    d_req = 1'b0; d_wen = 1'b0; d_type = 3'b010; d_addr = 32'h0; d_wd = 32'h0;

    // Reset with a pipeline store present
    @(negedge clk);
    check("rst_m_wen_c0", {31'd0, m_wen}, 32'd0);
    @(negedge clk);
    check("rst_m_wen", {31'd0, m_wen}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_d_rdy", {31'd0, d_rdy}, 32'd1);
    check("rst_p_stall", {31'd0, p_stall}, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; p_wen = 1'b0;

    // Idle pipeline: debug store then debug load of the same word
    drive_req(1'b1, 32'h10, 32'hA5A5_A5A5, 1'b1, 32'h0);
    wait_access(32'h10, 1'b1, 1, 1'b0, acc);
    finish_ack(acc);
    drive_req(1'b0, 32'h10, 32'h0, 1'b1, 32'hA5A5_A5A5);
    wait_access(32'h10, 1'b0, 1, 1'b0, acc);
    finish_ack(acc);

    // Pipeline store lands while the debug load is pending
    drive_req(1'b0, 32'h20, 32'h0, 1'b1, 32'd7);
    p_wen = 1'b1; p_addr = 32'h20; p_wd = 32'd7;
    @(negedge clk);
    check("pipe_store_addr", m_addr, 32'h20);
    check("pipe_store_wen", {31'd0, m_wen}, 32'd1);
    check("pipe_store_stall", {31'd0, p_stall}, 32'd0);
    @(posedge clk); #1;
    p_wen = 1'b0; p_addr = 32'h100;
    wait_access(32'h20, 1'b0, 1, 1'b0, acc);
    finish_ack(acc);

    // Continuous pipeline loads: starvation bound, twice from a clean reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; p_ren = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_req(1'b0, 32'h10, 32'h0, 1'b1, 32'hA5A5_A5A5);
      wait_access(32'h10, 1'b0, 4, 1'b1, acc);
      finish_ack(acc);
    end
`ifdef DMEM_ARB_PERF_EN
    check("perf_stall", perf_stall, 32'd2);
    check("perf_dbg", perf_dbg, 32'd2);
`else
    check("perf_stall_off", perf_stall, 32'd0);
    check("perf_dbg_off", perf_dbg, 32'd0);
`endif
    @(posedge clk); #1;
    p_ren = 1'b0;

    // Back-to-back: second request accepted in the first ack cycle
    drive_req(1'b1, 32'h30, 32'h1234_5678, 1'b1, 32'h0);
    wait_access(32'h30, 1'b1, 1, 1'b0, acc);
    drive_req(1'b0, 32'h30, 32'h0, 1'b1, 32'h1234_5678);
    check("b2b_first_ack", last_ack_cyc, acc + 1);
    wait_access(32'h30, 1'b0, 1, 1'b0, acc);
    finish_ack(acc);

    // Reset during the access cycle: store suppressed, no ack, nothing pending
    drive_req(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0);
    wait_access(32'h40, 1'b1, 1, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_d_ack", {31'd0, d_ack}, 32'd0);
    check("abort_d_rdy", {31'd0, d_rdy}, 32'd1);
    drive_req(1'b0, 32'h40, 32'h0, 1'b1, 32'h0);
    wait_access(32'h40, 1'b0, 1, 1'b0, acc);
    finish_ack(acc);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
